// File: rtl/uart_img_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_img_loader_pkg
// Shared constants and types for the PC->SNN image loader.
//   IMG_BITS / IMG_BYTES : image geometry (784 one-bit pixels, 98 bytes)
//   *_W                  : index and RAM address widths
//   ldr_state_t          : loader FSM state encoding
//   bit_addr()           : packs byte/bit indices into an image RAM bit address
// -----------------------------------------------------------------------------
package uart_img_loader_pkg;

    localparam int IMG_BITS   = 784;
    localparam int IMG_BYTES  = 98;
    localparam int BYTE_IDX_W = 7;
    localparam int BIT_IDX_W  = 3;
    localparam int RAM_ADDR_W = BYTE_IDX_W + BIT_IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ldr_state_t;

    function automatic logic [RAM_ADDR_W-1:0] bit_addr(
        input logic [BYTE_IDX_W-1:0] byte_idx,
        input logic [BIT_IDX_W-1:0]  bit_idx
    );
        return {byte_idx, bit_idx};
    endfunction

endpackage

// File: rtl/uart_img_loader_if.sv
// -----------------------------------------------------------------------------
// uart_img_loader_if
// Bundles the loader's byte input, image RAM write port, core handshake and
// status flags.
//   rx_rdy, rx_data          : byte strobe and data from uart_rx
//   ram_we, ram_addr, ram_wdata : bit-wide image RAM write port
//   img_valid, img_ack       : image-ready handshake with the SNN core
//   busy, overrun, timeout   : loader status
// Modports:
//   master : the loader itself (drives RAM port, handshake and status)
//   slave  : its environment (uart_rx, RAM, core)
// -----------------------------------------------------------------------------
interface uart_img_loader_if;
    import uart_img_loader_pkg::*;

    logic                  rx_rdy;
    logic [7:0]            rx_data;
    logic                  ram_we;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  ram_wdata;
    logic                  img_valid;
    logic                  img_ack;
    logic                  busy;
    logic                  overrun;
    logic                  timeout;

    modport master (
        input  rx_rdy, rx_data, img_ack,
        output ram_we, ram_addr, ram_wdata, img_valid, busy, overrun, timeout
    );

    modport slave (
        output rx_rdy, rx_data, img_ack,
        input  ram_we, ram_addr, ram_wdata, img_valid, busy, overrun, timeout
    );

endinterface

// File: rtl/uart_img_loader_idle_timer.sv
// -----------------------------------------------------------------------------
// uart_img_loader_idle_timer
// Counts idle clocks while a partial image is pending. Signals expiry on the
// clock where the count sits at TIMEOUT_CYCLES-1, then wraps back to zero.
//   clk, rst_n : system clock, async active-low reset
//   en_i       : count enable; counter is held at zero while low
//   clr_i      : synchronous clear (a byte arrived)
//   expire_o   : high for the single clock at terminal count while enabled
// -----------------------------------------------------------------------------
module uart_img_loader_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is reported even if a byte lands on the same clock; the parent
    // decides what that coincidence means.
    assign expire_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_img_loader.sv
// -----------------------------------------------------------------------------
// uart_img_loader
// Receives image bytes from uart_rx and unpacks each one LSB-first into a
// 1-bit-wide image RAM (bit j of byte i -> address 8*i+j). After the last
// byte, raises img_valid and holds it until the core acknowledges. A partial
// image left idle for TIMEOUT_CYCLES clocks is discarded.
//   clk, rst_n : system clock, async active-low reset
//   bus        : uart_img_loader_if.master (byte input, RAM port, handshake,
//                busy/overrun/timeout status)
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for the next byte; idle timer runs if mid-image
//   WRITE | shifting byte_buf into RAM, one bit per clock, 8 clocks
//   DONE  | full image in RAM, img_valid high until img_ack
// -----------------------------------------------------------------------------
module uart_img_loader #(
    parameter int IMG_BYTES      = uart_img_loader_pkg::IMG_BYTES,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_img_loader_if.master      bus
);
    import uart_img_loader_pkg::*;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(IMG_BYTES - 1);

    ldr_state_t            state_q,    state_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q,  bit_idx_d;
    logic [7:0]            byte_buf_q, byte_buf_d;
    logic                  overrun_q,  overrun_d;
    logic                  timeout_q,  timeout_d;

    logic timer_en;
    logic timer_expire;

    assign timer_en = (state_q == IDLE) && (byte_idx_q != '0);

    uart_img_loader_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (timer_en),
        .clr_i    (bus.rx_rdy),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        byte_buf_d = byte_buf_q;
        overrun_d  = overrun_q;
        timeout_d  = 1'b0;

        if (bus.img_ack) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.rx_rdy) begin
                    byte_buf_d = bus.rx_data;
                    bit_idx_d  = '0;
                    state_d    = WRITE;
                    // A byte coinciding with expiry starts a fresh image
                    // instead of continuing the stale one; no pulse.
                    if (timer_expire) begin
                        byte_idx_d = '0;
                    end
                end else if (timer_expire) begin
                    byte_idx_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            WRITE: begin
                bit_idx_d = bit_idx_q + 1'b1;
                if (bus.rx_rdy) begin
                    overrun_d = 1'b1;
                end
                if (bit_idx_q == 3'd7) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        state_d    = DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            DONE: begin
                if (bus.rx_rdy) begin
                    overrun_d = 1'b1;
                end
                if (bus.img_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            byte_buf_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            byte_buf_q <= byte_buf_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    // RAM port and handshake decode straight from state so an async reset
    // drops them in the same instant.
    assign bus.ram_we    = (state_q == WRITE);
    assign bus.ram_addr  = (state_q == WRITE) ? bit_addr(byte_idx_q, bit_idx_q) : '0;
    assign bus.ram_wdata = (state_q == WRITE) && byte_buf_q[bit_idx_q];
    assign bus.img_valid = (state_q == DONE);
    assign bus.busy      = (state_q == WRITE) || (state_q == DONE);
    assign bus.overrun   = overrun_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_uart_img_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_img_loader
// Directed bench for uart_img_loader. Each accepted byte pushes its eight
// expected RAM writes; a monitor records the writes the DUT makes and the
// stimulus thread pairs them up at checkpoints.
// -----------------------------------------------------------------------------
module tb_uart_img_loader;

    localparam int TB_TIMEOUT = 100;
    localparam int TB_BYTES   = 98;

    typedef struct {
        logic [9:0] addr;
        logic       d;
    } wr_t;

    logic clk;
    logic rst_n;

    uart_img_loader_if bus ();

    uart_img_loader #(
        .IMG_BYTES      (TB_BYTES),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors;
    int   miscompares;
    int   m_idx;
    int   tcount;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    logic tb_ram [0:1023];
    logic [7:0] img [0:TB_BYTES-1];

    always @(negedge clk) begin
        if (!rst_n) begin
            tcount <= 0;
            for (int k = 0; k < 1024; k++) tb_ram[k] <= 1'bx;
        end else begin
            if (bus.timeout) tcount <= tcount + 1;
            if (bus.ram_we) begin
                obs_q.push_back('{addr: bus.ram_addr, d: bus.ram_wdata});
                tb_ram[bus.ram_addr] <= bus.ram_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int nwr);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        for (int j = 0; j < nwr; j++) begin
            exp_q.push_back('{addr: 10'(m_idx * 8 + j), d: b[j]});
        end
        if (nwr > 0) m_idx = (m_idx == TB_BYTES - 1) ? 0 : m_idx + 1;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(bus.busy), 0);
    endtask

    task automatic drain();
        wr_t e;
        wr_t o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("wr_addr", 32'(o.addr), 32'(e.addr));
            chk("wr_data", 32'(o.d), 32'(e.d));
        end
        chk("wr_missing", exp_q.size(), 0);
        chk("wr_spurious", obs_q.size(), 0);
        exp_q.delete();
        obs_q.delete();
    endtask

    // Call at the first IDLE clock after a byte finishes writing.
    task automatic measure_timeout();
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus.timeout) break;
        end
        chk("timeout_latency", n, TB_TIMEOUT);
        @(negedge clk);
        chk("timeout_width", 32'(bus.timeout), 0);
        m_idx = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ram_we",    32'(bus.ram_we), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_img_valid", 32'(bus.img_valid), 0);
        chk("rst_overrun",   32'(bus.overrun), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int  n;
        bit  dropped;
        logic [7:0] got;

        vectors     = 0;
        miscompares = 0;
        m_idx       = 0;
        rst_n       = 1'b0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.img_ack = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_we",    32'(bus.ram_we), 0);
        chk("rst_ram_addr",  32'(bus.ram_addr), 0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
        chk("rst_img_valid", 32'(bus.img_valid), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_overrun",   32'(bus.overrun), 0);
        chk("rst_timeout",   32'(bus.timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte A5, then let the partial image time out
        send(8'hA5, 8);
        chk("a5_busy_start", 32'(bus.busy), 1);
        wait_idle(n);
        chk("a5_busy_8clk", n, 8);
        drain();
        measure_timeout();
        chk("a5_tcount", tcount, 1);

        // Second byte 3 clocks after the first is dropped
        send(8'h3C, 8);
        @(negedge clk);
        send(8'hFF, 0);
        chk("ovr_set", 32'(bus.overrun), 1);
        wait_idle(n);
        send(8'h81, 8);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        wait_idle(n);
        drain();
        @(negedge clk);
        bus.img_ack = 1'b1;
        @(negedge clk);
        bus.img_ack = 1'b0;
        chk("ovr_ack_clear", 32'(bus.overrun), 0);
        chk("ack_idle_valid", 32'(bus.img_valid), 0);
        chk("ack_idle_busy", 32'(bus.busy), 0);

        // Five bytes, idle timeout, next byte restarts at address 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i), 8);
            wait_idle(n);
        end
        drain();
        measure_timeout();
        send(8'h6E, 8);
        wait_idle(n);
        drain();

        // Full image
        do_reset();
        for (int i = 0; i < TB_BYTES; i++) begin
            img[i] = 8'($urandom);
            send(img[i], 8);
            if (i < TB_BYTES - 1) wait_idle(n);
        end
        repeat (7) @(negedge clk);
        chk("img_last_write_we", 32'(bus.ram_we), 1);
        chk("img_valid_early",   32'(bus.img_valid), 0);
        @(negedge clk);
        chk("img_valid_set",     32'(bus.img_valid), 1);
        chk("img_we_off",        32'(bus.ram_we), 0);
        chk("img_busy",          32'(bus.busy), 1);
        chk("img_overrun",       32'(bus.overrun), 0);
        chk("img_timeouts",      tcount, 0);
        drain();
        for (int i = 0; i < TB_BYTES; i++) begin
            for (int j = 0; j < 8; j++) got[j] = tb_ram[i * 8 + j];
            chk("ram_byte", 32'(got), 32'(img[i]));
        end

        // Hold in DONE with extra bytes arriving
        dropped = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            bus.rx_rdy = ((c % 50) == 10);
            if (!bus.img_valid) dropped = 1'b1;
        end
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        chk("hold_valid_kept", 32'(dropped), 0);
        chk("hold_overrun",    32'(bus.overrun), 1);
        drain();
        bus.img_ack = 1'b1;
        @(negedge clk);
        bus.img_ack = 1'b0;
        chk("ack_valid_clear", 32'(bus.img_valid), 0);
        chk("ack_ovr_clear",   32'(bus.overrun), 0);
        send(8'hC3, 8);
        wait_idle(n);
        drain();

        // Reset during the write of byte 40
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8);
            wait_idle(n);
        end
        send(8'h5A, 2);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ram_we",   32'(bus.ram_we), 0);
        chk("abort_ram_addr", 32'(bus.ram_addr), 0);
        chk("abort_busy",     32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain();
        m_idx = 0;
        send(8'h96, 8);
        wait_idle(n);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
